// File: rtl/count_hist_7seg_scan.sv
// Four-deep sample history of the counter, scanned onto a 4-digit common-anode hex display.
// Optional WRAP_DETECT_EN: per-entry wrap flags drive the decimal point and a wrap_pulse strobe.
module count_hist_7seg_scan #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic       sample,
  input  logic       clr_hist,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       wrap_pulse
);

  localparam int unsigned CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned NIB_W      = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  logic [DIGITS-1:0][NIB_W-1:0] hist;
  logic [DIGITS-1:0]            valid;
  logic [CNT_W-1:0]             ref_cnt;
  logic [1:0]                   dig;

  logic [DIGITS-1:0] an_c;
  logic [6:0]        seg_c;
  logic              dp_c;

  // Hex font, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'h40;
      4'h1:    f = 7'h79;
      4'h2:    f = 7'h24;
      4'h3:    f = 7'h30;
      4'h4:    f = 7'h19;
      4'h5:    f = 7'h12;
      4'h6:    f = 7'h02;
      4'h7:    f = 7'h78;
      4'h8:    f = 7'h00;
      4'h9:    f = 7'h10;
      4'hA:    f = 7'h08;
      4'hB:    f = 7'h03;
      4'hC:    f = 7'h46;
      4'hD:    f = 7'h21;
      4'hE:    f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  // Sample history shift register; clear wins over a coincident sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      valid <= '0;
    end else if (clr_hist) begin
      hist  <= '0;
      valid <= '0;
    end else if (sample) begin
      hist  <= {hist[DIGITS-2:0], q_in};
      valid <= {valid[DIGITS-2:0], 1'b1};
    end
  end

  // Free-running refresh divider and active-digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      dig     <= '0;
    end else if (ref_cnt == CNT_LAST) begin
      ref_cnt <= '0;
      dig     <= dig + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

`ifdef WRAP_DETECT_EN
  logic [DIGITS-1:0] wflag;
  logic              wflag_new_c;

  // A sample smaller than the previous one means the counter wrapped in between
  assign wflag_new_c = valid[0] & (q_in < hist[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wflag      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= sample & ~clr_hist & wflag_new_c;
      if (clr_hist) begin
        wflag <= '0;
      end else if (sample) begin
        wflag <= {wflag[DIGITS-2:0], wflag_new_c};
      end
    end
  end

  assign dp_c = ~(wflag[dig] & valid[dig]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp <= 1'b1;
    end else begin
      dp <= dp_c;
    end
  end
`else
  assign dp_c       = 1'b1;
  assign dp         = 1'b1;
  assign wrap_pulse = 1'b0;
`endif

  // Digit decode; anode and segments share one register stage so they switch together
  always_comb begin
    an_c  = AN_OFF ^ (4'b0001 << dig);
    seg_c = SEG_BLANK;
    if (valid[dig]) begin
      seg_c = hex_font(hist[dig]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_c;
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_count_hist_7seg_scan.sv
// Scoreboard bench for count_hist_7seg_scan with REFRESH_DIV=4; honours WRAP_DETECT_EN.
module tb_count_hist_7seg_scan;

  localparam int unsigned DIV = 4;
`ifdef WRAP_DETECT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q_in;
  logic       sample;
  logic       clr_hist;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       wrap_pulse;

  typedef struct {
    logic [1:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  count_hist_7seg_scan #(.REFRESH_DIV(DIV), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .sample     (sample),
    .clr_hist   (clr_hist),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] an_for(input logic [1:0] d);
    case (d)
      2'd0:    return 4'hE;
      2'd1:    return 4'hD;
      2'd2:    return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample = 1'b0; clr_hist = 1'b0; q_in = 4'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_digit(input logic [1:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an === an_for(d)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample = 1'b0; clr_hist = 1'b0; q_in = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    n_checks++; if (an !== 4'hF) $display("FAIL reset_an got %h want F", an); else n_pass++;
    n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7F", seg); else n_pass++;
    n_checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else n_pass++;
    n_checks++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap_pulse); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (an !== 4'hE) $display("FAIL reset_first_an got %h want E", an); else n_pass++;
    n_checks++; if (seg !== 7'h7F) $display("FAIL reset_first_seg got %h want 7F", seg); else n_pass++;
  endtask

  task automatic test_scan();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      want = an_for(2'((i / 4) % 4));
      n_checks++; if (an !== want) $display("FAIL scan_an cyc %0d got %h want %h", i, an, want); else n_pass++;
      n_checks++; if (seg !== 7'h7F) $display("FAIL scan_seg cyc %0d got %h want 7F", i, seg); else n_pass++;
      n_checks++; if (dp !== 1'b1) $display("FAIL scan_dp cyc %0d got %b want 1", i, dp); else n_pass++;
    end
  endtask

  task automatic test_fill();
    exp_t e;
    bit   ok;
    logic [3:0] vals [4] = '{4'h3, 4'h4, 4'h5, 4'h6};
    foreach (vals[i]) begin
      @(negedge clk);
      q_in = vals[i]; sample = 1'b1;
    end
    @(negedge clk);
    sample = 1'b0;
    sb.push_back('{2'd0, 7'h02, 1'b1});
    sb.push_back('{2'd1, 7'h12, 1'b1});
    sb.push_back('{2'd2, 7'h19, 1'b1});
    sb.push_back('{2'd3, 7'h30, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_digit(e.dig, ok);
      n_checks++; if (!ok) $display("FAIL fill_timeout digit %0d got an=%h want %h", e.dig, an, an_for(e.dig)); else n_pass++;
      n_checks++; if (seg !== e.seg) $display("FAIL fill_seg digit %0d got %h want %h", e.dig, seg, e.seg); else n_pass++;
      n_checks++; if (dp !== e.dp) $display("FAIL fill_dp digit %0d got %b want %b", e.dig, dp, e.dp); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    bit   ok;
    @(negedge clk);
    q_in = 4'hA; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    sb.push_back('{2'd0, 7'h08, 1'b1});
    sb.push_back('{2'd1, 7'h02, 1'b1});
    sb.push_back('{2'd2, 7'h12, 1'b1});
    sb.push_back('{2'd3, 7'h19, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_digit(e.dig, ok);
      n_checks++; if (!ok) $display("FAIL ovf_timeout digit %0d got an=%h want %h", e.dig, an, an_for(e.dig)); else n_pass++;
      n_checks++; if (seg !== e.seg) $display("FAIL ovf_seg digit %0d got %h want %h", e.dig, seg, e.seg); else n_pass++;
    end
  endtask

  task automatic test_clear_priority();
    exp_t e;
    bit   ok;
    @(negedge clk);
    q_in = 4'h9; sample = 1'b1; clr_hist = 1'b1;
    @(negedge clk);
    sample = 1'b0; clr_hist = 1'b0;
    n_checks++; if (wrap_pulse !== 1'b0) $display("FAIL clr_wrap got %b want 0", wrap_pulse); else n_pass++;
    for (int d = 0; d < 4; d++) sb.push_back('{2'(d), 7'h7F, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_digit(e.dig, ok);
      n_checks++; if (!ok) $display("FAIL clr_timeout digit %0d got an=%h want %h", e.dig, an, an_for(e.dig)); else n_pass++;
      n_checks++; if (seg !== e.seg) $display("FAIL clr_seg digit %0d got %h want %h", e.dig, seg, e.seg); else n_pass++;
      n_checks++; if (dp !== e.dp) $display("FAIL clr_dp digit %0d got %b want %b", e.dig, dp, e.dp); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   ok;
    logic want;
    logic [3:0] vals [3] = '{4'hE, 4'hF, 4'h0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = WRAP_EN && (i == 3);
      n_checks++; if (wrap_pulse !== want) $display("FAIL wrap_pulse cyc %0d got %b want %b", i, wrap_pulse, want); else n_pass++;
      if (i < 3) begin
        q_in = vals[i]; sample = 1'b1;
      end else begin
        sample = 1'b0;
      end
    end
    sb.push_back('{2'd0, 7'h40, !WRAP_EN});
    sb.push_back('{2'd1, 7'h0E, 1'b1});
    sb.push_back('{2'd2, 7'h06, 1'b1});
    sb.push_back('{2'd3, 7'h7F, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_digit(e.dig, ok);
      n_checks++; if (!ok) $display("FAIL wrap_timeout digit %0d got an=%h want %h", e.dig, an, an_for(e.dig)); else n_pass++;
      n_checks++; if (seg !== e.seg) $display("FAIL wrap_seg digit %0d got %h want %h", e.dig, seg, e.seg); else n_pass++;
      n_checks++; if (dp !== e.dp) $display("FAIL wrap_dp digit %0d got %b want %b", e.dig, dp, e.dp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_fill();
    test_overflow();
    test_clear_priority();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
